// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the main-memory arbiter and its fill counter.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int DEF_BLOCK_WORDS = 8;
  localparam int DEF_MEM_LAT     = 4;

  // Byte address of the first word of the block containing addr.
  function automatic logic [15:0] block_base(input logic [15:0] addr, input int words);
    return addr & ~16'(2 * words - 1);
  endfunction

endpackage

// File: rtl/fill_counter.sv
// Issue and return word counters for one block fill; wrap at BLOCK_WORDS.
module fill_counter import cpu_mem_pkg::*; #(
  parameter  int BLOCK_WORDS = DEF_BLOCK_WORDS,
  localparam int IDX_W       = $clog2(BLOCK_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             issue_en,
  input  logic             ret_en,
  output logic [IDX_W-1:0] issue_cnt,
  output logic [IDX_W-1:0] ret_cnt,
  output logic             issue_last,
  output logic             ret_last
);

  logic [IDX_W-1:0] issue_q, issue_d;
  logic [IDX_W-1:0] ret_q, ret_d;

  always_comb begin
    issue_d = issue_q;
    ret_d   = ret_q;
    if (clr) begin
      issue_d = '0;
      ret_d   = '0;
    end else begin
      if (issue_en) begin
        issue_d = issue_q + IDX_W'(1);
      end else begin
        issue_d = issue_q;
      end
      if (ret_en) begin
        ret_d = ret_q + IDX_W'(1);
      end else begin
        ret_d = ret_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q <= '0;
      ret_q   <= '0;
    end else begin
      issue_q <= issue_d;
      ret_q   <= ret_d;
    end
  end

  assign issue_cnt  = issue_q;
  assign ret_cnt    = ret_q;
  assign issue_last = (issue_q == IDX_W'(BLOCK_WORDS - 1));
  assign ret_last   = (ret_q == IDX_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates main memory between I-cache fills and D-cache fills/writes.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed D-over-I.
module mem_arbiter import cpu_mem_pkg::*; #(
  parameter  int MEM_LAT     = DEF_MEM_LAT,
  parameter  int BLOCK_WORDS = DEF_BLOCK_WORDS,
  localparam int IDX_W       = $clog2(BLOCK_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [15:0]      i_addr,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [15:0]      d_addr,
  input  logic [15:0]      d_wdata,
  output logic [15:0]      fill_data,
  output logic             i_fill_valid,
  output logic [IDX_W-1:0] i_fill_idx,
  output logic             i_done,
  output logic             d_fill_valid,
  output logic [IDX_W-1:0] d_fill_idx,
  output logic             d_done,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_rvalid
);

  if (MEM_LAT < 1) begin : g_lat_check
    $error("mem_arbiter: MEM_LAT must be at least 1");
  end

  arb_state_t       state_q, state_d;
  logic             owner_q, owner_d;
  logic [15:0]      base_q, base_d;
  logic             i_mask_q, d_mask_q;
  logic             i_act, d_act, grant_i, grant_d, idle;
  logic             cnt_clr, issue_en, ret_en, issue_last, ret_last;
  logic [IDX_W-1:0] issue_cnt, ret_cnt;

  // A port that completed last cycle is still holding req; mask it once.
  assign idle  = (state_q == IDLE);
  assign i_act = i_req & ~i_mask_q;
  assign d_act = d_req & ~d_mask_q;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    grant_d = idle & d_act & (~i_act | (last_q == PORT_I));
    grant_i = idle & i_act & ~grant_d;
    if (grant_d) begin
      last_d = PORT_D;
    end else if (grant_i) begin
      last_d = PORT_I;
    end else begin
      last_d = last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= PORT_I;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign grant_d = idle & d_act;
  assign grant_i = idle & i_act & ~d_act;
`endif

  fill_counter #(.BLOCK_WORDS(BLOCK_WORDS)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .issue_en  (issue_en),
    .ret_en    (ret_en),
    .issue_cnt (issue_cnt),
    .ret_cnt   (ret_cnt),
    .issue_last(issue_last),
    .ret_last  (ret_last)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    base_d       = base_q;
    cnt_clr      = 1'b0;
    issue_en     = 1'b0;
    ret_en       = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    fill_data    = 16'h0000;
    i_fill_valid = 1'b0;
    i_fill_idx   = '0;
    i_done       = 1'b0;
    d_fill_valid = 1'b0;
    d_fill_idx   = '0;
    d_done       = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = grant_d | grant_i;
        if (grant_d && d_we) begin
          state_d = WRITE;
        end else if (grant_d || grant_i) begin
          owner_d = grant_d ? PORT_D : PORT_I;
          base_d  = block_base(grant_d ? d_addr : i_addr, BLOCK_WORDS);
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE, DRAIN: begin
        if (state_q == ISSUE) begin
          mem_en   = 1'b1;
          mem_addr = base_q + 16'({issue_cnt, 1'b0});
          issue_en = 1'b1;
          state_d  = issue_last ? DRAIN : ISSUE;
        end else begin
          state_d = DRAIN;
        end
        // Returns are counted in both states; the last one ends the fill.
        if (mem_rvalid) begin
          ret_en    = 1'b1;
          fill_data = mem_rdata;
          if (owner_q == PORT_D) begin
            d_fill_valid = 1'b1;
            d_fill_idx   = ret_cnt;
            d_done       = ret_last;
          end else begin
            i_fill_valid = 1'b1;
            i_fill_idx   = ret_cnt;
            i_done       = ret_last;
          end
          if (ret_last) begin
            state_d = IDLE;
          end else begin
            state_d = state_d;
          end
        end else begin
          ret_en = 1'b0;
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_done    = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= PORT_I;
      base_q   <= 16'h0000;
      i_mask_q <= 1'b0;
      d_mask_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      base_q   <= base_d;
      i_mask_q <= i_done;
      d_mask_q <= d_done;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single pipelined main memory between the I-cache miss path (fetch stage) and the D-cache miss/write-through path (memory stage). Grants one requester at a time and runs either an 8-word block fill or a single-word write. For fills it issues sequential addresses, then counts the returning words and steers them to the owner with a word index. It sits between the two cache controllers and the memory model, so fetch_stage and memory_stage never drive memory directly.

Parameters:
MEM_LAT, 4, cycles from mem_en (read) to the matching mem_rvalid; must be >= 1
BLOCK_WORDS, 8, words per cache block; power of 2; IDX_W = clog2(BLOCK_WORDS)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
i_req  in  1  I-cache fill request; held with i_addr stable until i_done
i_addr  in  16  I-cache miss byte address
d_req  in  1  D-cache request; held with d_we/d_addr/d_wdata stable until d_done
d_we  in  1  1: single-word write, 0: block fill
d_addr  in  16  D-cache byte address
d_wdata  in  16  write data
fill_data  out  16  returning word, shared by both ports (= mem_rdata)
i_fill_valid  out  1  fill_data is word i_fill_idx for the I-cache
i_fill_idx  out  IDX_W  word index within the block
i_done  out  1  one-cycle pulse: I-cache transaction complete
d_fill_valid  out  1  as i_fill_valid, for the D-cache
d_fill_idx  out  IDX_W  as i_fill_idx, for the D-cache
d_done  out  1  one-cycle pulse: D-cache transaction complete
mem_en  out  1  memory access this cycle
mem_wr  out  1  1: write, 0: read (valid with mem_en)
mem_addr  out  16  memory byte address
mem_wdata  out  16  memory write data
mem_rdata  in  16  memory read data
mem_rvalid  in  1  mem_rdata valid

Behaviour:
- Reset: state IDLE, all counters 0, all outputs 0, last_served = I-port.
- FSM states: IDLE, ISSUE, DRAIN, WRITE.
- IDLE: arbitrate among active requests. Fixed priority: D over I. Any port that pulsed done in the previous cycle is masked for this cycle.
  - D-port granted with d_we=1: go to WRITE.
  - Otherwise (fill granted on either port): latch owner, latch base = addr & ~(2*BLOCK_WORDS-1), go to ISSUE.
- ISSUE: one read per cycle. mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt.
  - issue_cnt runs 0..BLOCK_WORDS-1.
  - After the last issue go to DRAIN.
- Returns, counted in ISSUE and DRAIN: on each mem_rvalid, assert the owner's fill_valid, drive fill_idx = ret_cnt, then increment ret_cnt.
  - On the BLOCK_WORDS-th return, pulse the owner's done in the same cycle and go to IDLE.
  - If MEM_LAT=1 the last return can arrive in the cycle after the last issue; this is handled in DRAIN.
- WRITE: one cycle. mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata, d_done=1. Next state IDLE.
- Timing: request seen in IDLE at cycle 0 → issues at cycles 1..8 → returns at cycles 1+MEM_LAT .. 8+MEM_LAT. Done coincides with the last return (cycle 12 at default MEM_LAT).
- Requester protocol: the requester drops req the cycle after done. The one-cycle done-mask prevents a stale re-grant.
- Any request arriving during a transaction waits. Requests are never dropped.
- mem_rvalid while in IDLE or WRITE is ignored: no fill_valid, no counter change. This covers stale returns after reset mid-fill.
- rst mid-transaction: return to reset values next cycle. No done is pulsed for the aborted transaction.
- fill_valid/done are never asserted for the non-owner. i_* and d_* outputs are never asserted together.
- Counters wrap at BLOCK_WORDS and are cleared on grant.

Optional Feature:
MEM_ARB_RR_EN: when defined, arbitration in IDLE is round-robin. When both ports request, the port != last_served wins. last_served updates on each grant and resets to the I-port, so the D-port wins the first tie. When undefined, fixed D-over-I priority applies and last_served is not built.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - arb_state_t enum (IDLE, ISSUE, DRAIN, WRITE)
  - port id constants PORT_I=0, PORT_D=1
  - BLOCK_WORDS and MEM_LAT defaults
- Natural sub-module: fill_counter. It holds the issue and return counters, increments on enable/rvalid, and raises a last flag at BLOCK_WORDS-1. It is instantiated once.

Test Plan:
- i_req=1, i_addr=0x1236, MEM_LAT=4, memory returns addr^0xA5A5 → mem_addr 0x1230..0x123E at cycles 1..8; i_fill_valid at cycles 5..12 with idx 0..7; data 0xB795..; i_done at cycle 12 only.
- i_req and d_req (fill, 0x4000) both high at cycle 0 → D block served first; i_done follows 12 cycles after d_done plus 1 mask/IDLE cycle; no I signals during D fill.
- d_req, d_we=1, d_addr=0x0044, d_wdata=0xBEEF → cycle 1: mem_en=1, mem_wr=1, addr 0x0044, data 0xBEEF, d_done=1; IDLE at cycle 2.
- rst asserted at cycle 6 of an I fill, mem_rvalid continues to cycle 12 → no i_fill_valid or i_done after reset; all outputs 0.
- MEM_ARB_RR_EN, both ports continuously requesting fills → grants alternate D, I, D, I; each port completes 8 words per grant.
- mem_rvalid pulsed in IDLE with no request → no fill_valid; next fill still starts at idx 0.
